// File: rtl/mult_div_unit_if.sv
// ---------------------------------------------------------------------------
// mult_div_unit_if
// Request/response bundle between the micro-controller and the multicycle
// signed MULT/DIV unit.
//   start    : begin an operation (only honoured while the unit is idle)
//   md_ctrl  : 0 = MULT, 1 = DIV, captured together with start
//   a, b     : rs / rt operands, captured together with start
//   hi, lo   : MULT product halves, or DIV remainder / quotient
//   busy     : unit is running an operation
//   done     : one-cycle completion pulse; hi/lo valid from the same edge
//   div0     : divide-by-zero flag, pulsed with done
// Modports: master = controller side, slave = arithmetic unit side.
// ---------------------------------------------------------------------------
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             md_ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div0;

  modport master (
    output start, md_ctrl, a, b,
    input  hi, lo, busy, done, div0
  );

  modport slave (
    input  start, md_ctrl, a, b,
    output hi, lo, busy, done, div0
  );
endinterface

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Multicycle signed multiply / restoring divide. An accepted start latches the
// operands, PREP takes magnitudes, ITER runs WIDTH shift steps, and FIX applies
// signs, registers hi/lo and pulses done. Worst case 34 clocks for WIDTH=32.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset; discards any in-flight operation
//   bus  : mult_div_unit_if.slave (start, md_ctrl, a, b -> hi, lo, busy,
//          done, div0)
// Optional feature macro: MULTDIV_DIV0_EN
//   defined     : DIV by zero is caught in PREP; done+div0 pulse one edge
//                 later, hi/lo left untouched.
//   not defined : div0 is tied low; DIV by zero runs the full sequence and
//                 returns hi = original dividend, lo = all ones.
// ---------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  mult_div_unit_if.slave    bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_ITER = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t           state_q,  state_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic             md_q,     md_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;   // MULT upper product / DIV remainder
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;   // MULT multiplier+lower product / DIV quotient
  logic [WIDTH-1:0] opnd_q,   opnd_d;     // MULT multiplicand / DIV divisor
  logic [WIDTH-1:0] hi_q,     hi_d;
  logic [WIDTH-1:0] lo_q,     lo_d;
  logic             done_q,   done_d;
  logic             div0_q,   div0_d;
`ifdef MULTDIV_DIV0_EN
  logic             zdiv_q,   zdiv_d;     // FIX only reports a zero divisor
`endif

  // Combinational datapath helpers
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_sh_s;
  logic [WIDTH:0]     div_trial_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   a_abs_s;
  logic [WIDTH-1:0]   b_abs_s;

  assign mul_sum_s   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign div_sh_s    = {acc_hi_q, acc_lo_q[WIDTH-1]};
  // Bit WIDTH of the trial difference is set exactly when it went negative.
  assign div_trial_s = div_sh_s - {1'b0, opnd_q};
  assign prod_s      = {acc_hi_q, acc_lo_q};
  // The most negative value maps onto itself, which is the right unsigned magnitude.
  assign a_abs_s     = a_q[WIDTH-1] ? (~a_q + {{(WIDTH-1){1'b0}}, 1'b1}) : a_q;
  assign b_abs_s     = b_q[WIDTH-1] ? (~b_q + {{(WIDTH-1){1'b0}}, 1'b1}) : b_q;

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.div0 = div0_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= {CW{1'b0}};
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      md_q     <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_hi_q <= {WIDTH{1'b0}};
      acc_lo_q <= {WIDTH{1'b0}};
      opnd_q   <= {WIDTH{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
`ifdef MULTDIV_DIV0_EN
      zdiv_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      a_q      <= a_d;
      b_q      <= b_d;
      md_q     <= md_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
`ifdef MULTDIV_DIV0_EN
      zdiv_q   <= zdiv_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    a_d      = a_q;
    b_d      = b_q;
    md_d     = md_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    div0_d   = 1'b0;
`ifdef MULTDIV_DIV0_EN
    zdiv_d   = zdiv_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          md_d     = bus.md_ctrl;
          sign_a_d = bus.a[WIDTH-1];
          sign_b_d = bus.b[WIDTH-1];
          state_d  = S_PREP;
        end else begin
          state_d  = S_IDLE;
        end
      end

      S_PREP: begin
        count_d  = {CW{1'b0}};
        acc_hi_d = {WIDTH{1'b0}};
        if (md_q) begin
          acc_lo_d = a_abs_s;
          opnd_d   = b_abs_s;
        end else begin
          acc_lo_d = b_abs_s;
          opnd_d   = a_abs_s;
        end
        state_d  = S_ITER;
`ifdef MULTDIV_DIV0_EN
        // Zero divisor: skip the iterations, FIX only raises the flag.
        if (md_q && (b_q == {WIDTH{1'b0}})) begin
          zdiv_d  = 1'b1;
          state_d = S_FIX;
        end else begin
          zdiv_d  = 1'b0;
        end
`endif
      end

      S_ITER: begin
        if (md_q) begin
          if (!div_trial_s[WIDTH]) begin
            acc_hi_d = div_trial_s[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = div_sh_s[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          // {carry, acc_hi, acc_lo} >> 1 after the conditional add
          acc_hi_d = mul_sum_s[WIDTH:1];
          acc_lo_d = {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};
        end
        count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
        if (count_q == CW'(WIDTH-1)) begin
          state_d = S_FIX;
        end else begin
          state_d = S_ITER;
        end
      end

      S_FIX: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
`ifdef MULTDIV_DIV0_EN
        if (zdiv_q) begin
          div0_d = 1'b1;
          zdiv_d = 1'b0;
        end else
`endif
        if (md_q) begin
          if (b_q == {WIDTH{1'b0}}) begin
            hi_d = a_q;
            lo_d = {WIDTH{1'b1}};
          end else begin
            // Truncating division: quotient sign = sign_a^sign_b, remainder follows dividend.
            lo_d = (sign_a_q ^ sign_b_q) ? (~acc_lo_q + {{(WIDTH-1){1'b0}}, 1'b1}) : acc_lo_q;
            hi_d = sign_a_q ? (~acc_hi_q + {{(WIDTH-1){1'b0}}, 1'b1}) : acc_hi_q;
          end
        end else begin
          if (sign_a_q ^ sign_b_q) begin
            {hi_d, lo_d} = ~prod_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
          end else begin
            {hi_d, lo_d} = prod_s;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
// Directed self-checking bench for mult_div_unit: hand-computed MULT/DIV
// vectors, done timing, start-while-busy, back-to-back start and
// asynchronous reset in the middle of an operation.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   edges;
  int   busy_n;
  int   ndone;
  int   done_edge;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one operation at edge 0 and wait (bounded) for done.
  // edges = edge index of done, busy_n = edges with busy high before done.
  task automatic run_op(input logic md, input logic [31:0] av, input logic [31:0] bv,
                        output int e, output int bn);
    bus.md_ctrl = md;
    bus.a       = av;
    bus.b       = bv;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    e  = 0;
    bn = (bus.busy === 1'b1) ? 1 : 0;
    while (bus.done !== 1'b1 && e < 60) begin
      tick();
      e++;
      if (bus.busy === 1'b1 && bus.done !== 1'b1) bn++;
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    bus.start   = 1'b0;
    bus.md_ctrl = 1'b0;
    bus.a       = 32'd0;
    bus.b       = 32'd0;
    rst = 1'b1;
    #12;
    chk("rst_hi",   bus.hi,   32'h0);
    chk("rst_lo",   bus.lo,   32'h0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_div0", {31'd0, bus.div0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // MULT 7 * -3 = -21
    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, edges, busy_n);
    chk("m1_edge", 32'(edges), 32'd34);
    chk("m1_busy", 32'(busy_n), 32'd34);
    chk("m1_hi",   bus.hi, 32'hFFFF_FFFF);
    chk("m1_lo",   bus.lo, 32'hFFFF_FFEB);
    chk("m1_div0", {31'd0, bus.div0}, 32'd0);
    tick();
    chk("m1_pulse", {31'd0, bus.done}, 32'd0);
    chk("m1_idle",  {31'd0, bus.busy}, 32'd0);
    chk("m1_hold",  bus.lo, 32'hFFFF_FFEB);

    // MULT 0x80000000 * 0x80000000 = 2^62
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, edges, busy_n);
    chk("m2_edge", 32'(edges), 32'd34);
    chk("m2_hi",   bus.hi, 32'h4000_0000);
    chk("m2_lo",   bus.lo, 32'h0);

    // MULT -1 * -1 = 1
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, edges, busy_n);
    chk("m3_hi", bus.hi, 32'h0);
    chk("m3_lo", bus.lo, 32'h1);

    // DIV -7 / 2 = -3 rem -1
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, edges, busy_n);
    chk("d1_edge", 32'(edges), 32'd34);
    chk("d1_lo",   bus.lo, 32'hFFFF_FFFD);
    chk("d1_hi",   bus.hi, 32'hFFFF_FFFF);

    // DIV 0x80000000 / -1 wraps to 0x80000000 rem 0
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, edges, busy_n);
    chk("d2_lo",   bus.lo, 32'h8000_0000);
    chk("d2_hi",   bus.hi, 32'h0);
    chk("d2_div0", {31'd0, bus.div0}, 32'd0);

    // DIV 100 / -7 = -14 rem 2
    run_op(1'b1, 32'd100, 32'hFFFF_FFF9, edges, busy_n);
    chk("d3_lo", bus.lo, 32'hFFFF_FFF2);
    chk("d3_hi", bus.hi, 32'd2);

    // DIV 5 / 0
    run_op(1'b1, 32'd5, 32'd0, edges, busy_n);
`ifdef MULTDIV_DIV0_EN
    chk("dz_edge", 32'(edges), 32'd2);
    chk("dz_div0", {31'd0, bus.div0}, 32'd1);
    chk("dz_hi",   bus.hi, 32'd2);
    chk("dz_lo",   bus.lo, 32'hFFFF_FFF2);
`else
    chk("dz_edge", 32'(edges), 32'd34);
    chk("dz_div0", {31'd0, bus.div0}, 32'd0);
    chk("dz_hi",   bus.hi, 32'd5);
    chk("dz_lo",   bus.lo, 32'hFFFF_FFFF);
`endif
    tick();
    chk("dz_pulse", {31'd0, bus.done | bus.div0}, 32'd0);

    // start pulses at edges 5 and 20 of a MULT 6*7 are ignored
    bus.md_ctrl = 1'b0;
    bus.a       = 32'd6;
    bus.b       = 32'd7;
    bus.start   = 1'b1;
    tick();
    ndone     = 0;
    done_edge = 0;
    for (int e = 1; e <= 45; e++) begin
      bus.start = (e == 5 || e == 20) ? 1'b1 : 1'b0;
      tick();
      if (bus.done === 1'b1) begin
        ndone++;
        done_edge = e;
      end
    end
    bus.start = 1'b0;
    chk("ign_ndone", 32'(ndone), 32'd1);
    chk("ign_edge",  32'(done_edge), 32'd34);
    chk("ign_lo",    bus.lo, 32'd42);

    // Back-to-back: start held through done, second op latched at edge 35
    bus.md_ctrl = 1'b0;
    bus.a       = 32'd2;
    bus.b       = 32'd3;
    bus.start   = 1'b1;
    tick();
    edges = 0;
    while (bus.done !== 1'b1 && edges < 60) begin
      tick();
      edges++;
    end
    chk("b2b_edge1", 32'(edges), 32'd34);
    chk("b2b_lo1",   bus.lo, 32'd6);
    bus.a = 32'd10;
    bus.b = 32'd10;
    tick();
    bus.start = 1'b0;
    chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
    done_edge = 35;
    edges = 0;
    while (bus.done !== 1'b1 && edges < 60) begin
      tick();
      edges++;
    end
    chk("b2b_edge2", 32'(done_edge + edges), 32'd69);
    chk("b2b_lo2",   bus.lo, 32'd100);

    // Reset at edge 15 of a DIV discards it
    bus.md_ctrl = 1'b1;
    bus.a       = 32'd100;
    bus.b       = 32'd7;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int e = 1; e <= 14; e++) tick();
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk("rs_hi",   bus.hi, 32'h0);
    chk("rs_lo",   bus.lo, 32'h0);
    chk("rs_busy", {31'd0, bus.busy}, 32'd0);
    #3;
    rst = 1'b0;
    ndone = 0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (bus.done === 1'b1) ndone++;
    end
    chk("rs_nodone", 32'(ndone), 32'd0);

    // Fresh MULT 3 * 4 after reset
    run_op(1'b0, 32'd3, 32'd4, edges, busy_n);
    chk("rs_m_edge", 32'(edges), 32'd34);
    chk("rs_m_hi",   bus.hi, 32'h0);
    chk("rs_m_lo",   bus.lo, 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
